// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite master controller: FSM states,
// response codes and strobe-width helper.
package axi4_lite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_RSP     = 3'd5,
        ST_DRAIN   = 3'd6
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axi4_lite_timeout_cnt.sv
// Response-wait counter: cleared outside the wait states, counts unanswered
// cycles and flags expiry once it reaches TIMEOUT_CYCLES (never when 0).
module axi4_lite_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    import axi4_lite_pkg::*;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    // Saturates at LIMIT so a stalled FSM can never wrap the count.
    always_ff @(posedge ACLK) begin
        if (ARESET || clear)
            cnt <= '0;
        else if (enable && cnt != LIMIT)
            cnt <= cnt + 1'b1;
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);

endmodule

// File: rtl/axi4_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master: one command in, five AXI channels out,
// one response back; late responses after a timeout are drained.
module axi4_lite_master_ctrl
    import axi4_lite_pkg::*;
#(
    parameter int         ADDRESS_WIDTH  = 32,
    parameter int         DATA_WIDTH     = 32,
    parameter int         TIMEOUT_CYCLES = 256,
    parameter logic [2:0] PROT_VALUE     = 3'b000
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]           cmd_addr,
    input  logic [DATA_WIDTH-1:0]              cmd_wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0]  cmd_wstrb,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic                               rsp_write,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic [1:0]                         rsp_resp,
    output logic                               rsp_timeout,
    output logic [ADDRESS_WIDTH-1:0]           M_AXI_AWADDR,
    output logic                               M_AXI_AWVALID,
    input  logic                               M_AXI_AWREADY,
    output logic [2:0]                         M_AXI_AWPROT,
    output logic [DATA_WIDTH-1:0]              M_AXI_WDATA,
    output logic [strb_width(DATA_WIDTH)-1:0]  M_AXI_WSTRB,
    output logic                               M_AXI_WVALID,
    input  logic                               M_AXI_WREADY,
    input  logic [1:0]                         M_AXI_BRESP,
    input  logic                               M_AXI_BVALID,
    output logic                               M_AXI_BREADY,
    output logic [ADDRESS_WIDTH-1:0]           M_AXI_ARADDR,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    output logic [2:0]                         M_AXI_ARPROT,
    input  logic [DATA_WIDTH-1:0]              M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY
);

    state_t state;
    logic   aw_done, w_done;
    logic   aw_hs, w_hs;
    logic   tmo_clear, tmo_enable, tmo_expired;

    assign M_AXI_ARPROT = PROT_VALUE;
    assign M_AXI_AWPROT = PROT_VALUE;

    assign aw_hs      = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs       = M_AXI_WVALID & M_AXI_WREADY;
    // Counter only runs while waiting on R/B; address stalls never expire.
    assign tmo_clear  = !(state == ST_RD_DATA || state == ST_WR_RESP);
    assign tmo_enable = (state == ST_RD_DATA && !M_AXI_RVALID) ||
                        (state == ST_WR_RESP && !M_AXI_BVALID);

    axi4_lite_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            rsp_timeout   <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready   <= 1'b0;
                        rsp_write   <= cmd_write;
                        rsp_timeout <= 1'b0;
                        if (cmd_write) begin
                            M_AXI_AWADDR  <= cmd_addr;
                            M_AXI_WDATA   <= cmd_wdata;
                            M_AXI_WSTRB   <= cmd_wstrb;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= ST_WR_ADDR;
                        end else begin
                            M_AXI_ARADDR  <= cmd_addr;
                            M_AXI_ARVALID <= 1'b1;
                            state         <= ST_RD_ADDR;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    // A beat in the expiry cycle still wins over the timeout.
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end else if (tmo_expired) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_resp     <= RESP_DECERR;
                        rsp_timeout  <= 1'b1;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end
                end
                ST_WR_ADDR: begin
                    if (aw_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        M_AXI_WVALID <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end else if (tmo_expired) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_resp     <= RESP_DECERR;
                        rsp_timeout  <= 1'b1;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_timeout) begin
                            M_AXI_BREADY <= rsp_write;
                            M_AXI_RREADY <= !rsp_write;
                            state        <= ST_DRAIN;
                        end else begin
                            cmd_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Swallow the one late beat the slave still owes us.
                    if ((M_AXI_RREADY && M_AXI_RVALID) || (M_AXI_BREADY && M_AXI_BVALID)) begin
                        M_AXI_RREADY <= 1'b0;
                        M_AXI_BREADY <= 1'b0;
                        cmd_ready    <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
